// File: rtl/mf_pkg.sv
// Shared types and constants for the Multiface-style freeze controller:
// FSM state encoding, register-shadow offsets inside the overlay RAM, port high bytes.
package mf_pkg;

  typedef enum logic [1:0] {
    MF_OFF  = 2'd0,
    MF_PEND = 2'd1,
    MF_ON   = 2'd2
  } mf_state_e;

  // Opcode-fetch addresses that drive the FSM
  localparam logic [15:0] NMI_VEC  = 16'h0066;
  localparam logic [15:0] HIDE_VEC = 16'h0065;

  // High address bytes of the write-only hardware ports that are shadowed
  localparam logic [7:0] HI_GA       = 8'h7F;
  localparam logic [7:0] HI_CRTC_SEL = 8'hBC;
  localparam logic [7:0] HI_CRTC_DAT = 8'hBD;
  localparam logic [7:0] HI_PPI      = 8'hF7;
  localparam logic [7:0] HI_ROM_SEL  = 8'hDF;

  // Shadow byte offsets within the overlay RAM
  localparam logic [15:0] OFS_PEN_SEL   = 16'h1FCF;
  localparam logic [15:0] OFS_PEN_BASE  = 16'h1F90;
  localparam logic [15:0] OFS_BORDER    = 16'h1FDF;
  localparam logic [15:0] OFS_GA_MODE   = 16'h1FEF;
  localparam logic [15:0] OFS_GA_RAM    = 16'h1FFF;
  localparam logic [15:0] OFS_CRTC_SEL  = 16'h1CFF;
  localparam logic [15:0] OFS_CRTC_BASE = 16'h1DB0;
  localparam logic [15:0] OFS_PPI       = 16'h17FF;
  localparam logic [15:0] OFS_ROM_SEL   = 16'h1AAC;

endpackage

// File: rtl/mf_shadow_ram.sv
// Single-port overlay RAM: one shared address, writes take the port and the
// written byte is returned on the read data (write-first bypass).
module mf_shadow_ram #(
  parameter int unsigned AW = 13
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mf_freezer_ctrl.sv
// Multiface-style freeze controller: freeze key -> NMI, overlay ROM/RAM paged into
// the low 16K, write-only hardware registers shadowed into the overlay RAM.
module mf_freezer_ctrl
  import mf_pkg::*;
#(
  parameter int unsigned RAM_AW    = 13,
  parameter logic [8:0]  ROM_PAGE  = 9'h1ff,
  parameter int unsigned CRTC_REGS = 16,
  parameter int unsigned NMI_TMO   = 65535,
  parameter logic [15:0] PORT_BASE = 16'hFEE8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        key_nmi,
  input  logic        m1,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        io_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic        nmi,
  output logic        mf_en,
  output logic        mf_hidden,
  output logic        rom_en,
  output logic        ram_en,
  output logic [22:0] rom_addr,
  output logic        sdram_wr_block,
  output logic [7:0]  dout
);

  logic              r_key_s1, r_key_s2, r_key_old;
  logic              r_old_m1, r_old_io_wr, r_old_mem_wr;
  mf_state_e         r_state, w_state_nxt;
  logic [15:0]       r_tmo_cnt;
  logic              r_hidden;
  logic [4:0]        r_pen, r_crtc_sel;
  logic              r_pend_v;
  logic [RAM_AW-1:0] r_pend_addr;
  logic [7:0]        r_pend_data;

  logic              w_key_rise, w_m1_rise, w_io_rise, w_wr_rise;
  logic              w_port_hit, w_page_in, w_page_out, w_tmo_done;
  logic              w_st_hit, w_cpu_wr, w_we;
  logic [15:0]       w_st_ofs;
  logic [RAM_AW-1:0] w_waddr, w_ram_addr;
  logic [7:0]        w_wdata, w_ram_q;

  // key_nmi is asynchronous to the bus, so it is double-synchronised before edge detection
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_key_s1     <= 1'b0;
      r_key_s2     <= 1'b0;
      r_key_old    <= 1'b0;
      r_old_m1     <= 1'b0;
      r_old_io_wr  <= 1'b0;
      r_old_mem_wr <= 1'b0;
    end else begin
      r_key_s1     <= key_nmi;
      r_key_s2     <= r_key_s1;
      r_key_old    <= r_key_s2;
      r_old_m1     <= m1;
      r_old_io_wr  <= io_wr;
      r_old_mem_wr <= mem_wr;
    end
  end

  assign w_key_rise = r_key_s2 & ~r_key_old;
  assign w_m1_rise  = m1 & ~r_old_m1;
  assign w_io_rise  = io_wr & ~r_old_io_wr;
  assign w_wr_rise  = mem_wr & ~r_old_mem_wr;
  assign w_port_hit = (cpu_addr[15:2] == PORT_BASE[15:2]);
  assign w_page_in  = w_io_rise & w_port_hit & ~cpu_addr[1];
  assign w_page_out = w_io_rise & w_port_hit & cpu_addr[1];
  assign w_tmo_done = (NMI_TMO != 0) && (r_tmo_cnt == 16'd1);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= MF_OFF;
      r_tmo_cnt <= '0;
      r_hidden  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != MF_PEND)
        r_tmo_cnt <= '0;
      else if (r_state != MF_PEND)
        r_tmo_cnt <= 16'(NMI_TMO);
      else if (r_tmo_cnt != '0)
        r_tmo_cnt <= r_tmo_cnt - 16'd1;
      if (r_state == MF_PEND && w_state_nxt == MF_ON)
        r_hidden <= 1'b0;
      else if (r_state == MF_ON && w_m1_rise && cpu_addr == HIDE_VEC)
        r_hidden <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MF_OFF: begin
        if (w_page_in && !r_hidden) w_state_nxt = MF_ON;
        else if (w_key_rise)        w_state_nxt = MF_PEND;
      end
      MF_PEND: begin
        if (w_m1_rise && cpu_addr == NMI_VEC) w_state_nxt = MF_ON;
        else if (w_tmo_done)                  w_state_nxt = MF_OFF;
      end
      MF_ON: begin
        if (w_page_out) w_state_nxt = MF_OFF;
      end
      default: w_state_nxt = MF_OFF;
    endcase
  end

  always_comb begin
    nmi       = (r_state == MF_PEND);
    mf_en     = (r_state == MF_ON);
    mf_hidden = r_hidden;
  end

  assign rom_en         = mf_en & (cpu_addr[15:13] == 3'b000);
  assign ram_en         = mf_en & (cpu_addr[15:13] == 3'b001);
  assign rom_addr       = {ROM_PAGE, cpu_addr[13:0]};
  assign sdram_wr_block = rom_en | ram_en;

  // Page ports share no high byte with shadowed ports, but the explicit check keeps them exclusive
  always_comb begin
    w_st_hit = 1'b0;
    w_st_ofs = '0;
    if (w_io_rise && !w_port_hit) begin
      case (cpu_addr[15:8])
        HI_GA: begin
          w_st_hit = 1'b1;
          case (cpu_dout[7:6])
            2'b00:   w_st_ofs = OFS_PEN_SEL;
            2'b01:   w_st_ofs = r_pen[4] ? OFS_BORDER : OFS_PEN_BASE + {12'd0, r_pen[3:0]};
            2'b10:   w_st_ofs = OFS_GA_MODE;
            default: w_st_ofs = OFS_GA_RAM;
          endcase
        end
        HI_CRTC_SEL: begin
          w_st_hit = 1'b1;
          w_st_ofs = OFS_CRTC_SEL;
        end
        HI_CRTC_DAT: begin
          if ({27'd0, r_crtc_sel} < CRTC_REGS) begin
            w_st_hit = 1'b1;
            w_st_ofs = OFS_CRTC_BASE + {11'd0, r_crtc_sel};
          end
        end
        HI_PPI: begin
          w_st_hit = 1'b1;
          w_st_ofs = OFS_PPI;
        end
        HI_ROM_SEL: begin
          w_st_hit = 1'b1;
          w_st_ofs = OFS_ROM_SEL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_pen      <= '0;
      r_crtc_sel <= '0;
    end else if (w_io_rise && !w_port_hit) begin
      if (cpu_addr[15:8] == HI_GA && cpu_dout[7:6] == 2'b00) r_pen <= cpu_dout[4:0];
      if (cpu_addr[15:8] == HI_CRTC_SEL)                     r_crtc_sel <= cpu_dout[4:0];
    end
  end

  assign w_cpu_wr = w_wr_rise & ram_en;

  // Write arbitration: shadow store first, then a deferred CPU write, then a fresh one
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_pend_addr;
    w_wdata = r_pend_data;
    if (w_st_hit) begin
      w_we    = 1'b1;
      w_waddr = w_st_ofs[RAM_AW-1:0];
      w_wdata = cpu_dout;
    end else if (r_pend_v) begin
      w_we = 1'b1;
    end else if (w_cpu_wr) begin
      w_we    = 1'b1;
      w_waddr = cpu_addr[RAM_AW-1:0];
      w_wdata = cpu_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else if (w_cpu_wr && (w_st_hit || r_pend_v)) begin
      r_pend_v    <= 1'b1;
      r_pend_addr <= cpu_addr[RAM_AW-1:0];
      r_pend_data <= cpu_dout;
    end else if (!w_st_hit) begin
      r_pend_v <= 1'b0;
    end
  end

  assign w_ram_addr = w_we ? w_waddr : cpu_addr[RAM_AW-1:0];

  mf_shadow_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .i_clk   (clk_sys),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_q)
  );

  assign dout = (ram_en && mem_rd) ? w_ram_q : 8'hFF;

endmodule
